// File: rtl/hazard_ctrl.sv
// Hazard-control unit for the 5-stage MIPS pipeline: load-use, branch-in-ID and
// multiply/divide interlocks, IF flush on taken control transfers, stall counter.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              if_id_branch,
    input  logic              if_id_uses_hilo,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              md_start,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_flush,
    output logic              md_busy,
    output logic [1:0]        stall_cause,
    output logic [CNT_W-1:0]  stall_count
);
    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_LOAD   = 2'd1,
        CAUSE_BRANCH = 2'd2,
        CAUSE_MD     = 2'd3
    } cause_e;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             match_ex, match_mem;
    logic             load_use, br_dep, md_stall, stall;
    cause_e           cause;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic src_match(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              uses_rt
    );
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign match_ex  = src_match(id_ex_rd,  if_id_rs, if_id_rt, if_id_uses_rt);
    assign match_mem = src_match(ex_mem_rd, if_id_rs, if_id_rt, if_id_uses_rt);

    // Branches compare in ID, so they must wait for an ALU result in EX and for
    // load data still in MEM; this yields one and two bubbles respectively.
    assign load_use = id_ex_mem_read && match_ex;
    assign br_dep   = (if_id_branch || jump)
                   && ((id_ex_reg_write && match_ex) || (ex_mem_mem_read && match_mem));
    assign md_busy  = !reset && (md_cnt_q != '0);
    assign md_stall = if_id_uses_hilo && md_busy;
    assign stall    = !reset && (load_use || br_dep || md_stall);

    always_comb begin
        cause = CAUSE_NONE;
        if (stall) begin
            if (load_use)    cause = CAUSE_LOAD;
            else if (br_dep) cause = CAUSE_BRANCH;
            else             cause = CAUSE_MD;
        end
    end

    // A stalled branch is still unresolved, so the stall suppresses the flush.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_flush     = 1'b0;
        if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!reset) begin
            if_flush = jump || (if_id_branch && branch_taken);
        end
    end

    assign stall_cause = cause;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start)
            md_cnt_d = MD_LOAD;
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MD_W'(1);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=3 instance
// sharing the same stimulus to exercise counter saturation.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic [4:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic       if_id_uses_rt, if_id_branch, if_id_uses_hilo;
    logic       branch_taken, jump, md_start, perf_clr;
    logic       pc_write, if_id_write, id_ex_bubble, if_flush, md_busy;
    logic [1:0] stall_cause;
    logic [15:0] stall_count;
    logic       pc_write_s, if_id_write_s, id_ex_bubble_s, if_flush_s, md_busy_s;
    logic [1:0] stall_cause_s;
    logic [2:0] stall_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_branch(if_id_branch), .if_id_uses_hilo(if_id_uses_hilo),
        .branch_taken(branch_taken), .jump(jump), .md_start(md_start), .perf_clr(perf_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_flush(if_flush), .md_busy(md_busy), .stall_cause(stall_cause),
        .stall_count(stall_count)
    );

    hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_branch(if_id_branch), .if_id_uses_hilo(if_id_uses_hilo),
        .branch_taken(branch_taken), .jump(jump), .md_start(md_start), .perf_clr(perf_clr),
        .pc_write(pc_write_s), .if_id_write(if_id_write_s), .id_ex_bubble(id_ex_bubble_s),
        .if_flush(if_flush_s), .md_busy(md_busy_s), .stall_cause(stall_cause_s),
        .stall_count(stall_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0;
        ex_mem_mem_read = 0; ex_mem_rd = 0; if_id_rs = 0; if_id_rt = 0;
        if_id_uses_rt = 0; if_id_branch = 0; if_id_uses_hilo = 0;
        branch_taken = 0; jump = 0; md_start = 0; perf_clr = 0;
    endtask

    task automatic chk_stall(input string tag, input logic [1:0] cause);
        chk({tag, ".pc_write"},    pc_write,     (cause == 0));
        chk({tag, ".if_id_write"}, if_id_write,  (cause == 0));
        chk({tag, ".bubble"},      id_ex_bubble, (cause != 0));
        chk({tag, ".cause"},       stall_cause,  cause);
    endtask

    initial begin
        clr_in();
        reset = 1;
        // Load-use and a multiply issue during reset must not take effect.
        id_ex_mem_read = 1; id_ex_rd = 2; if_id_rs = 2; md_start = 1;
        tick();
        settle();
        chk_stall("rst_hold", 2'd0);
        chk("rst_hold.md_busy", md_busy, 0);
        chk("rst_hold.count", stall_count, 0);
        tick();
        clr_in();
        reset = 0;
        settle();
        chk("post_rst.md_busy", md_busy, 0);
        chk("post_rst.count", stall_count, 0);
        chk("post_rst.flush", if_flush, 0);

        // lw $2 in EX, ID reads $2
        id_ex_mem_read = 1; id_ex_rd = 2; if_id_rs = 2;
        settle();
        chk_stall("ld_use", 2'd1);
        chk("ld_use.flush", if_flush, 0);
        tick();
        clr_in();
        settle();
        chk_stall("ld_use_done", 2'd0);
        chk("ld_use_done.count", stall_count, 1);
        // $0 never creates a dependency
        id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs = 0;
        settle();
        chk_stall("ld_r0", 2'd0);
        // rt only counts when the ID instruction reads it
        id_ex_rd = 5; if_id_rs = 1; if_id_rt = 5; if_id_uses_rt = 0;
        settle();
        chk_stall("ld_rt_unused", 2'd0);
        if_id_uses_rt = 1;
        settle();
        chk_stall("ld_rt_used", 2'd1);
        tick();
        clr_in();
        settle();
        chk("ld_rt.count", stall_count, 2);

        // beq $3 behind ALU producer of $3; taken but stalled -> no flush
        if_id_branch = 1; if_id_rs = 3; id_ex_reg_write = 1; id_ex_rd = 3; branch_taken = 1;
        settle();
        chk_stall("br_alu", 2'd2);
        chk("br_alu.flush", if_flush, 0);
        tick();
        id_ex_reg_write = 0; id_ex_rd = 0; ex_mem_rd = 3;
        settle();
        chk_stall("br_alu_go", 2'd0);
        chk("br_alu_go.flush", if_flush, 1);
        branch_taken = 0;
        settle();
        chk("br_nt.flush", if_flush, 0);
        tick();
        clr_in();
        settle();
        chk("br_alu.count", stall_count, 3);

        // beq $4 behind lw $4: load-use first, then MEM-stage load dependency
        if_id_branch = 1; if_id_rs = 4; branch_taken = 1;
        id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = 4;
        settle();
        chk_stall("br_ld1", 2'd1);
        tick();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0;
        ex_mem_mem_read = 1; ex_mem_rd = 4;
        settle();
        chk_stall("br_ld2", 2'd2);
        chk("br_ld2.flush", if_flush, 0);
        tick();
        ex_mem_mem_read = 0;
        settle();
        chk_stall("br_ld3", 2'd0);
        chk("br_ld3.flush", if_flush, 1);
        tick();
        clr_in();
        settle();
        chk("br_ld.count", stall_count, 5);

        // jr $7 behind ALU producer of $7, then jump alone flushes
        jump = 1; if_id_rs = 7; id_ex_reg_write = 1; id_ex_rd = 7;
        settle();
        chk_stall("jr_dep", 2'd2);
        tick();
        id_ex_reg_write = 0; id_ex_rd = 0;
        settle();
        chk_stall("jr_go", 2'd0);
        chk("jr_go.flush", if_flush, 1);
        tick();
        clr_in();
        settle();
        chk("jr.count", stall_count, 6);

        // mult at cycle 0, mfhi in ID from cycle 1: four stall cycles
        md_start = 1;
        settle();
        chk("md0.busy", md_busy, 0);
        tick();
        md_start = 0; if_id_uses_hilo = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("md.busy", md_busy, 1);
            chk_stall("md", 2'd3);
            tick();
        end
        settle();
        chk("md_done.busy", md_busy, 0);
        chk_stall("md_done", 2'd0);
        chk("md.count", stall_count, 10);
        chk("md.count_sat", stall_count_s, 7);
        clr_in();

        // md_start while busy reloads the full latency
        md_start = 1;
        tick();
        md_start = 0;
        tick();
        md_start = 1;
        tick();
        md_start = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("md_reload.busy", md_busy, 1);
            tick();
        end
        settle();
        chk("md_reload.end", md_busy, 0);

        // clear wins over a simultaneous stall
        id_ex_mem_read = 1; id_ex_rd = 9; if_id_rs = 9; perf_clr = 1;
        tick();
        perf_clr = 0;
        settle();
        chk("clr_stall.count", stall_count, 0);
        chk("clr_stall.count_sat", stall_count_s, 0);
        for (int i = 0; i < 10; i++) tick();
        settle();
        chk("sat.count", stall_count, 10);
        chk("sat.count_sat", stall_count_s, 7);
        clr_in();
        perf_clr = 1;
        tick();
        perf_clr = 0;
        settle();
        chk("clr.count", stall_count, 0);

        // reset at cycle 2 of a multiply aborts the interlock
        md_start = 1;
        tick();
        md_start = 0;
        tick();
        reset = 1; if_id_uses_hilo = 1;
        settle();
        chk("md_rst.pc_write", pc_write, 1);
        chk("md_rst.busy", md_busy, 0);
        chk("md_rst.cause", stall_cause, 0);
        tick();
        reset = 0;
        settle();
        chk("md_rst_after.busy", md_busy, 0);
        chk("md_rst_after.count", stall_count, 0);
        chk_stall("md_rst_after", 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard-control unit for the 5-stage MIPS pipeline, replacing the combinational load-use/branch detector. It sits beside the IF/ID and ID/EX registers and drives PC write-enable, IF/ID write-enable, ID/EX bubble insertion and IF flush. It adds the stalls needed when branches resolve in ID with operands still in flight, an interlock for a multi-cycle multiply/divide unit, and a saturating stall-cycle counter. All enables are active-high: 1 = write/advance.

## Interface
- REG_AW, 5, register-address width
- MD_LAT, 4, multiply/divide latency in cycles after issue (≥1)
- CNT_W, 16, stall-counter width

- clk  in  1  clock; the only clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_reg_write  in  1  instruction in EX writes a register
- id_ex_rd  in  REG_AW  destination register of the EX instruction
- ex_mem_mem_read  in  1  instruction in MEM is a load
- ex_mem_rd  in  REG_AW  destination register of the MEM instruction
- if_id_rs, if_id_rt  in  REG_AW  source registers of the ID instruction
- if_id_uses_rt  in  1  ID instruction reads rt
- if_id_branch  in  1  ID instruction is beq/bne
- if_id_uses_hilo  in  1  ID instruction is mfhi/mflo/mult/div
- branch_taken  in  1  branch condition resolved in ID is true
- jump  in  1  ID instruction is j/jal/jr
- md_start  in  1  multiply/divide issued in EX this cycle
- perf_clr  in  1  clear stall counter
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID update enable
- id_ex_bubble  out  1  zero control signals entering ID/EX
- if_flush  out  1  squash the instruction in IF/ID
- md_busy  out  1  multiply/divide in progress
- stall_cause  out  2  0 none, 1 load-use, 2 branch dependency, 3 md busy
- stall_count  out  CNT_W  cycles spent stalled

## Operation
- match(r) = (r != 0) && (r == if_id_rs || (if_id_uses_rt && r == if_id_rt)).
- load_use = id_ex_mem_read && match(id_ex_rd).
- br_dep = (if_id_branch || jump) && ((id_ex_reg_write && match(id_ex_rd)) || (ex_mem_mem_read && match(ex_mem_rd))). This gives 1 stall behind an ALU producer and 2 stalls behind a load.
- md_stall = if_id_uses_hilo && md_busy.
- stall = !reset && (load_use || br_dep || md_stall).
- On stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0.
- With no stall: pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush = jump || (if_id_branch && branch_taken).
- Stall overrides flush because the branch is unresolved while stalled.
- stall_cause uses priority load-use > branch > md, and is 0 when no stall.
- MD counter md_cnt has width clog2(MD_LAT+1).
  - If md_start: load MD_LAT.
  - Else if nonzero: decrement.
  - md_busy = (md_cnt != 0).
  - md_start while busy reloads the counter.
- stall_count:
  - perf_clr: set to 0.
  - Else if stall: increment, saturating at all-ones.
  - perf_clr and stall in the same cycle: the clear wins.

## Timing
- Stall, flush and bubble outputs are combinational from the inputs and current state: zero latency within the cycle.
- md_start sampled at edge t makes md_busy high for exactly MD_LAT cycles following edge t.
- stall_count reflects a stall one cycle later, after the edge.
- Reset (synchronous):
  - md_cnt=0 and stall_count=0 at the edge.
  - While reset is high: pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=0, stall_cause=0, md_busy=0.
  - Reset mid-multiply aborts the interlock.
- Register 0 never creates a dependency.

## Test plan
- lw $2 in EX (id_ex_mem_read=1, id_ex_rd=2), ID reads rs=2 -> pc_write=0, id_ex_bubble=1, stall_cause=1 for 1 cycle. Same with rd=0 -> no stall.
- beq in ID with rs=3; ALU producer of $3 in EX -> 1 stall cycle (cause 2). Then branch_taken=1 -> if_flush=1, pc_write=1.
- beq rs=4 following lw $4: cycle 1 cause 1, cycle 2 cause 2 (ex_mem_mem_read match), cycle 3 flush/advance. Total 2 stalls.
- MD_LAT=4: md_start at cycle 0, mfhi in ID at cycle 1 -> stalls cycles 1-4 (cause 3), advances cycle 5. stall_count increments by 4.
- Saturation with CNT_W=3: hold stall for 10 cycles -> stall_count stops at 7. perf_clr together with stall -> 0.
- Reset asserted at cycle 2 of a multiply -> md_busy=0 the next cycle, stall_count=0, pc_write=1 during reset.
